// File: rtl/mem_responder_if.sv
// Request/grant/response bus between the cache memory port (master) and mem_responder (slave).
interface mem_responder_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        error_o;

  modport master (
    output req_i, addr_i, wdata_i, we_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, error_o
  );

  modport slave (
    input  req_i, addr_i, wdata_i, we_i, be_i,
    output gnt_o, rvalid_o, rdata_o, error_o
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: byte-enable RAM with configurable grant delay, in-order
// fixed-latency responses and a bounded number of outstanding requests.
module mem_responder #(
  parameter int          ADDR_WIDTH      = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          GNT_DELAY       = 0,
  parameter int          RVALID_LATENCY  = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_responder_if.slave bus
);

  localparam int          DEPTH  = 1 << ADDR_WIDTH;
  localparam int          LAT    = RVALID_LATENCY;
  localparam logic [3:0]  GD_C   = 4'(GNT_DELAY);
  localparam logic [3:0]  MAX_C  = 4'(MAX_OUTSTANDING);
  localparam logic [32:0] SPAN_C = 33'(DEPTH) << 2;

  logic [31:0]           r_mem [DEPTH];
  logic [3:0]            r_gcnt;
  logic [3:0]            r_outst;
  logic [LAT-1:0]        r_pv;
  logic [LAT-1:0]        r_pe;
  logic [31:0]           r_pd [LAT];

  logic [31:0]           w_off;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_eff;
  logic                  w_full;
  logic                  w_gnt;
  logic                  w_ent_err;
  logic [31:0]           w_ent_data;
  logic [3:0]            w_gcnt_nxt;

  // Decode, grant and response-entry formation
  always_comb begin
    w_off      = bus.addr_i - BASE_ADDR;
    w_in_range = ({1'b0, w_off} < SPAN_C);
    w_idx      = w_off[ADDR_WIDTH+1:2];
    // A response leaving this cycle frees its slot for a grant in the same cycle.
    w_eff      = r_outst - {3'b000, r_pv[LAT-1]};
    w_full     = (w_eff >= MAX_C);
    w_gnt      = reset_n && bus.req_i && (r_gcnt == GD_C) && !w_full;
    w_ent_err  = 1'b0;
    w_ent_data = 32'h0000_0000;
    w_gcnt_nxt = r_gcnt;
    if (w_gnt) begin
      if (w_in_range) begin
        if (!bus.we_i) begin
          w_ent_data = r_mem[w_idx];
        end else begin
          w_ent_data = 32'h0000_0000;
        end
      end else begin
        w_ent_err = 1'b1;
      end
    end else begin
      w_ent_err = 1'b0;
    end
    if (!bus.req_i || w_gnt) begin
      w_gcnt_nxt = 4'd0;
    end else if (!w_full && (r_gcnt != GD_C)) begin
      w_gcnt_nxt = r_gcnt + 4'd1;
    end else begin
      w_gcnt_nxt = r_gcnt;
    end
  end

  // Grant-delay and outstanding counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gcnt  <= 4'd0;
      r_outst <= 4'd0;
    end else begin
      r_gcnt  <= w_gcnt_nxt;
      r_outst <= w_eff + {3'b000, w_gnt};
    end
  end

  // Response shift register; empty stages carry zeros so outputs need no masking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pv <= '0;
      r_pe <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pd[i] <= 32'h0000_0000;
      end
    end else begin
      r_pv[0] <= w_gnt;
      r_pe[0] <= w_ent_err;
      r_pd[0] <= w_ent_data;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  // Byte-enable RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_gnt && bus.we_i && w_in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.be_i[n]) begin
          r_mem[w_idx][8*n +: 8] <= bus.wdata_i[8*n +: 8];
        end
      end
    end
  end

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_pv[LAT-1];
  assign bus.error_o  = r_pe[LAT-1];
  assign bus.rdata_o  = r_pd[LAT-1];

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed tables/sequences on three configurations plus a
// randomized run on a fourth checked against a transaction-level reference model.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d;

  mem_responder_if ifa ();
  mem_responder_if ifb ();
  mem_responder_if ifc ();
  mem_responder_if ifd ();

  mem_responder dut_a (.clk(clk), .reset_n(rst_a), .bus(ifa));
  mem_responder #(.GNT_DELAY(2), .RVALID_LATENCY(1), .MAX_OUTSTANDING(1))
    dut_b (.clk(clk), .reset_n(rst_b), .bus(ifb));
  mem_responder #(.GNT_DELAY(0), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2))
    dut_c (.clk(clk), .reset_n(rst_c), .bus(ifc));
  mem_responder #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_2000), .GNT_DELAY(1),
                  .RVALID_LATENCY(3), .MAX_OUTSTANDING(2))
    dut_d (.clk(clk), .reset_n(rst_d), .bus(ifd));

  localparam int          GD_D   = 1;
  localparam int          LAT_D  = 3;
  localparam int          MAX_D  = 2;
  localparam logic [31:0] BASE_D = 32'h0000_2000;
  localparam int          NV     = 14;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  int checks   = 0;
  int failures = 0;

  vec_t        vt [NV];
  req_t        pend[$];
  rsp_t        rsp_q[$];
  logic [31:0] mmem [16];
  logic [31:0] cval [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    ifc.req_i   = req;
    ifc.we_i    = we;
    ifc.addr_i  = addr;
    ifc.wdata_i = wdata;
    ifc.be_i    = 4'hF;
  endtask

  initial begin
    req_t        cur;
    bit          active;
    bit          head_due;
    bit          exp_gnt;
    int          wait_n;
    int          cyc;
    int          eff;
    int          off;
    logic [31:0] o;
    logic [31:0] rdat;
    logic        rerr;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
    vt[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0};
    vt[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    vt[5]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0};
    vt[6]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
    vt[7]  = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1};
    vt[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};
    vt[9]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vt[10] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
    vt[11] = '{1'b0, 32'h0000_0FFE, 32'h0000_0000, 4'h0, 32'hA5A5_A5A5, 1'b0};
    vt[12] = '{1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, 4'hF, 32'h0000_0000, 1'b1};
    vt[13] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};

    ifa.req_i = 1'b1; ifa.we_i = 1'b0; ifa.addr_i = 32'h0; ifa.wdata_i = 32'h0; ifa.be_i = 4'h0;
    ifb.req_i = 1'b0; ifb.we_i = 1'b0; ifb.addr_i = 32'h0; ifb.wdata_i = 32'h0; ifb.be_i = 4'h0;
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    ifd.req_i = 1'b0; ifd.we_i = 1'b0; ifd.addr_i = 32'h0; ifd.wdata_i = 32'h0; ifd.be_i = 4'h0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

    // Reset state, with a request held high on A
    #12;
    chk("rst_gnt",    32'(ifa.gnt_o),    32'd0);
    chk("rst_rvalid", 32'(ifa.rvalid_o), 32'd0);
    chk("rst_rdata",  ifa.rdata_o,       32'd0);
    chk("rst_error",  32'(ifa.error_o),  32'd0);
    ifa.req_i = 1'b0;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    @(negedge clk);

    // A: table of single accesses (GNT_DELAY=0, latency 1)
    for (int i = 0; i < NV; i++) begin
      ifa.req_i   = 1'b1;
      ifa.we_i    = vt[i].we;
      ifa.addr_i  = vt[i].addr;
      ifa.wdata_i = vt[i].wdata;
      ifa.be_i    = vt[i].be;
      #1;
      chk($sformatf("a_gnt[%0d]", i), 32'(ifa.gnt_o), 32'd1);
      @(negedge clk);
      chk($sformatf("a_rvalid[%0d]", i), 32'(ifa.rvalid_o), 32'd1);
      chk($sformatf("a_rdata[%0d]", i),  ifa.rdata_o,       vt[i].exp_rdata);
      chk($sformatf("a_error[%0d]", i),  32'(ifa.error_o),  32'(vt[i].exp_err));
      ifa.req_i = 1'b0;
      @(negedge clk);
      chk($sformatf("a_rvalid_off[%0d]", i), 32'(ifa.rvalid_o), 32'd0);
    end

    // B: grant delay of 2, applied per request
    ifb.req_i = 1'b1; ifb.we_i = 1'b1; ifb.addr_i = 32'h20; ifb.wdata_i = 32'h0BAD_CAFE; ifb.be_i = 4'hF;
    #1 chk("b_gnt_c0", 32'(ifb.gnt_o), 32'd0);
    @(negedge clk); chk("b_gnt_c1", 32'(ifb.gnt_o), 32'd0);
    @(negedge clk); chk("b_gnt_c2", 32'(ifb.gnt_o), 32'd1);
    @(negedge clk);
    ifb.we_i = 1'b0; ifb.wdata_i = 32'h0;
    #1;
    chk("b_wr_rvalid", 32'(ifb.rvalid_o), 32'd1);
    chk("b_wr_rdata",  ifb.rdata_o,       32'd0);
    chk("b_gnt_r0",    32'(ifb.gnt_o),    32'd0);
    @(negedge clk); chk("b_gnt_r1", 32'(ifb.gnt_o), 32'd0);
    @(negedge clk); chk("b_gnt_r2", 32'(ifb.gnt_o), 32'd1);
    @(negedge clk);
    ifb.req_i = 1'b0;
    #1;
    chk("b_rd_rvalid", 32'(ifb.rvalid_o), 32'd1);
    chk("b_rd_rdata",  ifb.rdata_o,       32'h0BAD_CAFE);

    // C: preload three words, then exercise the outstanding limit
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cval[k] = $urandom;
      drive_c(1'b1, 1'b1, 32'(4 * k), cval[k]);
      #1 chk($sformatf("c_pre_gnt[%0d]", k), 32'(ifc.gnt_o), 32'd1);
      @(negedge clk);
      drive_c(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) @(negedge clk);
    end
    drive_c(1'b1, 1'b0, 32'h0, 32'h0);
    #1 chk("c_gnt_0", 32'(ifc.gnt_o), 32'd1);
    @(negedge clk); drive_c(1'b1, 1'b0, 32'h4, 32'h0);
    #1 chk("c_gnt_4", 32'(ifc.gnt_o), 32'd1);
    @(negedge clk); drive_c(1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    chk("c_gnt_8_full", 32'(ifc.gnt_o),    32'd0);
    chk("c_rv_k2",      32'(ifc.rvalid_o), 32'd0);
    @(negedge clk); #1;
    chk("c_gnt_8_free", 32'(ifc.gnt_o),    32'd1);
    chk("c_rv_k3",      32'(ifc.rvalid_o), 32'd1);
    chk("c_rd_k3",      ifc.rdata_o,       cval[0]);
    @(negedge clk); drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("c_rv_k4", 32'(ifc.rvalid_o), 32'd1);
    chk("c_rd_k4", ifc.rdata_o,       cval[1]);
    @(negedge clk); #1 chk("c_rv_k5", 32'(ifc.rvalid_o), 32'd0);
    @(negedge clk); #1;
    chk("c_rv_k6", 32'(ifc.rvalid_o), 32'd1);
    chk("c_rd_k6", ifc.rdata_o,       cval[2]);

    // C: reset pulse one cycle after an accept drops the response
    repeat (3) @(negedge clk);
    drive_c(1'b1, 1'b0, 32'h4, 32'h0);
    #1 chk("c_rst_gnt_pre", 32'(ifc.gnt_o), 32'd1);
    @(negedge clk);
    drive_c(1'b1, 1'b0, 32'h8, 32'h0);
    rst_c = 1'b0;
    #1;
    chk("c_rst_gnt",    32'(ifc.gnt_o),    32'd0);
    chk("c_rst_rvalid", 32'(ifc.rvalid_o), 32'd0);
    @(negedge clk);
    rst_c = 1'b1;
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("c_rst_quiet[%0d]", k), 32'(ifc.rvalid_o), 32'd0);
      @(negedge clk);
    end
    drive_c(1'b1, 1'b0, 32'h8, 32'h0);
    #1 chk("c_post_gnt", 32'(ifc.gnt_o), 32'd1);
    @(negedge clk); drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("c_post_rvalid", 32'(ifc.rvalid_o), 32'd1);
    chk("c_post_rdata",  ifc.rdata_o,       cval[2]);

    // C: reset while a response is visible clears outputs at once
    @(negedge clk);
    @(negedge clk);
    drive_c(1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk); drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("c_live_rvalid", 32'(ifc.rvalid_o), 32'd1);
    chk("c_live_rdata",  ifc.rdata_o,       cval[0]);
    #1 rst_c = 1'b0;
    #1;
    chk("c_async_rvalid", 32'(ifc.rvalid_o), 32'd0);
    chk("c_async_rdata",  ifc.rdata_o,       32'd0);
    @(negedge clk); rst_c = 1'b1;

    // D: randomized traffic against the reference model
    for (int w = 0; w < 16; w++) begin
      pend.push_back('{1'b1, BASE_D + 32'(4 * w), $urandom, 4'hF});
    end
    for (int n = 0; n < 300; n++) begin
      off = int'($urandom_range(0, 19)) - 2;
      pend.push_back('{1'($urandom_range(0, 1)),
                       BASE_D + 32'(off * 4) + 32'($urandom_range(0, 3)),
                       $urandom, 4'($urandom_range(0, 15))});
    end
    cur    = '{1'b0, 32'h0, 32'h0, 4'h0};
    active = 1'b0;
    wait_n = 0;
    cyc    = 0;
    @(negedge clk);
    for (int c = 0; c < 8000; c++) begin
      if (!active && (pend.size() > 0) && ($urandom_range(0, 3) != 0)) begin
        cur    = pend.pop_front();
        active = 1'b1;
      end
      ifd.req_i   = active;
      ifd.we_i    = cur.we;
      ifd.addr_i  = cur.addr;
      ifd.wdata_i = cur.wdata;
      ifd.be_i    = cur.be;
      #1;
      head_due = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
      eff      = rsp_q.size() - (head_due ? 1 : 0);
      exp_gnt  = active && (wait_n == GD_D) && (eff < MAX_D);
      chk("d_rvalid", 32'(ifd.rvalid_o), 32'(head_due));
      chk("d_rdata",  ifd.rdata_o,       head_due ? rsp_q[0].data : 32'd0);
      chk("d_error",  32'(ifd.error_o),  head_due ? 32'(rsp_q[0].err) : 32'd0);
      chk("d_gnt",    32'(ifd.gnt_o),    32'(exp_gnt));
      @(posedge clk);
      cyc++;
      if (head_due) void'(rsp_q.pop_front());
      if (exp_gnt) begin
        o    = cur.addr - BASE_D;
        rdat = 32'h0;
        rerr = 1'b1;
        if (o < 32'd64) begin
          rerr = 1'b0;
          if (cur.we) begin
            for (int b = 0; b < 4; b++) begin
              if (cur.be[b]) mmem[o >> 2][8*b +: 8] = cur.wdata[8*b +: 8];
            end
          end else begin
            rdat = mmem[o >> 2];
          end
        end
        rsp_q.push_back('{cyc + LAT_D - 1, rerr, rdat});
        active = 1'b0;
        wait_n = 0;
      end else if (!active) begin
        wait_n = 0;
      end else if ((eff < MAX_D) && (wait_n < GD_D)) begin
        wait_n++;
      end
      if (!active && (pend.size() == 0) && (rsp_q.size() == 0)) break;
      @(negedge clk);
    end
    chk("d_drain", 32'(pend.size() + rsp_q.size() + int'(active)), 32'd0);
    ifd.req_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
